// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO: state encoding and the
// next-state priority rule used by the control FSM.
package fifo_pkg;

  // Seven control states in a 3-bit encoding
  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    WR_RD  = 3'd4,
    WR_ERR = 3'd5,
    RD_ERR = 3'd6
  } fifo_state_e;

  // A rejected write outranks a rejected read; otherwise the state names what was accepted
  function automatic fifo_state_e selectNextState(input logic wrAccept,
                                                  input logic rdAccept,
                                                  input logic wrReject,
                                                  input logic rdReject);
    fifo_state_e nextState;
    nextState = IDLE;
    if (wrReject)                  nextState = WR_ERR;
    else if (rdReject)             nextState = RD_ERR;
    else if (wrAccept && rdAccept) nextState = WR_RD;
    else if (wrAccept)             nextState = WRITE;
    else if (rdAccept)             nextState = READ;
    return nextState;
  endfunction

endpackage

// File: rtl/register_bank.sv
// Storage array for the FIFO: one-hot write enable, combinational read select.
module register_bank
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_resetN,
  input  logic [DEPTH-1:0]      i_wrOneHot,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic [ADDR_W-1:0]     i_rdSel,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Each entry loads the write data when its one-hot enable bit is set
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wrOneHot[i]) begin
          r_mem[i] <= i_wrData;
        end
      end
    end
  end

  assign o_rdData = r_mem[i_rdSel];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: pointers, occupancy count, status flags
// and control FSM live here; entries are held in register_bank.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_W:0]       data_count
);

  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  fifo_state_e           r_state;
  fifo_state_e           w_nextState;
  logic [ADDR_W-1:0]     r_head;
  logic [ADDR_W-1:0]     r_tail;
  logic [ADDR_W:0]       r_count;
  logic [DATA_WIDTH-1:0] r_dOut;
  logic                  r_wrAck;
  logic                  r_wrErr;
  logic                  r_rdAck;
  logic                  r_rdErr;

  logic                  w_active;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wrAccept;
  logic                  w_wrReject;
  logic                  w_rdAccept;
  logic                  w_rdReject;
  logic [DEPTH-1:0]      w_wrOneHot;
  logic [DATA_WIDTH-1:0] w_rdData;

  // Flags come from the registered count only, so they never see this cycle's requests
  assign w_full   = (r_count == COUNT_MAX);
  assign w_empty  = (r_count == '0);

  // Requests sampled in INIT are dropped entirely
  assign w_active   = (r_state != INIT);
  assign w_wrAccept = w_active & wr_en & ~w_full;
  assign w_wrReject = w_active & wr_en &  w_full;
  assign w_rdAccept = w_active & rd_en & ~w_empty;
  assign w_rdReject = w_active & rd_en &  w_empty;

  assign w_wrOneHot = {{(DEPTH-1){1'b0}}, w_wrAccept} << r_tail;

  register_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_registerBank (
    .i_clk      (clk),
    .i_resetN   (reset_n),
    .i_wrOneHot (w_wrOneHot),
    .i_wrData   (d_in),
    .i_rdSel    (r_head),
    .o_rdData   (w_rdData)
  );

  // Next state follows the reject-first priority; INIT always falls through to IDLE
  always_comb begin
    w_nextState = IDLE;
    w_nextState = selectNextState(w_wrAccept, w_rdAccept, w_wrReject, w_rdReject);
  end

  // State register, parked in INIT while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pointers wrap naturally at ADDR_W bits; count moves only on a lone accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wrAccept) r_tail <= r_tail + PTR_ONE;
      if (w_rdAccept) r_head <= r_head + PTR_ONE;
      case ({w_wrAccept, w_rdAccept})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data is captured only on an accepted read and otherwise held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dOut <= '0;
    end else if (w_rdAccept) begin
      r_dOut <= w_rdData;
    end
  end

  // Per-request status pulses for the cycle after the request is sampled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrAck <= 1'b0;
      r_wrErr <= 1'b0;
      r_rdAck <= 1'b0;
      r_rdErr <= 1'b0;
    end else begin
      r_wrAck <= w_wrAccept;
      r_wrErr <= w_wrReject;
      r_rdAck <= w_rdAccept;
      r_rdErr <= w_rdReject;
    end
  end

  assign d_out      = r_dOut;
  assign full       = w_full;
  assign empty      = w_empty;
  assign data_count = r_count;
  assign wr_ack     = r_wrAck;
  assign wr_err     = r_wrErr;
  assign rd_ack     = r_rdAck;
  assign rd_err     = r_rdErr;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a queue model.
module tb_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [AW:0]   data_count;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn    = 1'b0;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .d_in       (d_in),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored entries plus last read value and status bits
  logic [DW-1:0] mQ[$];
  logic [DW-1:0] mDout  = '0;
  bit            mInit  = 1'b1;
  bit            mWrAck = 1'b0;
  bit            mWrErr = 1'b0;
  bit            mRdAck = 1'b0;
  bit            mRdErr = 1'b0;

  always @(posedge clk or negedge reset_n) begin : refModel
    bit wA, wE, rA, rE;
    if (!reset_n) begin
      mQ.delete();
      mDout  = '0;
      mInit  = 1'b1;
      mWrAck = 1'b0; mWrErr = 1'b0; mRdAck = 1'b0; mRdErr = 1'b0;
    end else if (mInit) begin
      mInit  = 1'b0;
      mWrAck = 1'b0; mWrErr = 1'b0; mRdAck = 1'b0; mRdErr = 1'b0;
    end else begin
      wA = wr_en && (mQ.size() <  DEPTH);
      wE = wr_en && (mQ.size() == DEPTH);
      rA = rd_en && (mQ.size() >  0);
      rE = rd_en && (mQ.size() == 0);
      if (rA) mDout = mQ.pop_front();
      if (wA) mQ.push_back(d_in);
      mWrAck = wA; mWrErr = wE; mRdAck = rA; mRdErr = rE;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output with the model on each falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model d_out",      d_out,              mDout);
      checkOutput("model full",       32'(full),          32'(mQ.size() == DEPTH));
      checkOutput("model empty",      32'(empty),         32'(mQ.size() == 0));
      checkOutput("model data_count", 32'(data_count),    32'(mQ.size()));
      checkOutput("model wr_ack",     32'(wr_ack),        32'(mWrAck));
      checkOutput("model wr_err",     32'(wr_err),        32'(mWrErr));
      checkOutput("model rd_ack",     32'(rd_ack),        32'(mRdAck));
      checkOutput("model rd_err",     32'(rd_err),        32'(mRdErr));
    end
  end

  // Hold inputs across one rising edge, return 1 time unit after it
  task automatic applyStimulus(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] wrapData;
    int bias;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    d_in    = '0;

    // Values while reset is held
    #7;
    checkEn = 1'b1;
    checkOutput("reset empty", 32'(empty),      32'd1);
    checkOutput("reset full",  32'(full),       32'd0);
    checkOutput("reset count", 32'(data_count), 32'd0);
    checkOutput("reset d_out", d_out,           32'h0);

    // Release between edges; the first edge is spent in INIT and ignores the write
    #5;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF);
    checkOutput("init ignores write ack", 32'(wr_ack),     32'd0);
    checkOutput("init ignores write cnt", 32'(data_count), 32'd0);

    // Read on an empty FIFO
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("empty read rd_err", 32'(rd_err),     32'd1);
    checkOutput("empty read d_out",  d_out,           32'h0);
    checkOutput("empty read empty",  32'(empty),      32'd1);
    checkOutput("empty read count",  32'(data_count), 32'd0);

    // Fill with 11..88, then one write too many
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i * 32'h11));
      checkOutput("fill wr_ack", 32'(wr_ack), 32'd1);
    end
    checkOutput("fill full",  32'(full),       32'd1);
    checkOutput("fill count", 32'(data_count), 32'd8);
    applyStimulus(1'b1, 1'b0, 32'h99);
    checkOutput("overflow wr_err", 32'(wr_err),     32'd1);
    checkOutput("overflow count",  32'(data_count), 32'd8);

    // Drain in order, then one read too many
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("drain d_out",  d_out,       32'(i * 32'h11));
      checkOutput("drain rd_ack", 32'(rd_ack), 32'd1);
    end
    checkOutput("drain empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("underflow rd_err", 32'(rd_err), 32'd1);
    checkOutput("underflow d_out",  d_out,       32'h88);

    // Wrap-around: 5 in, 5 out, then 6 across the pointer wrap
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h50 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("wrap pre d_out", d_out, 32'h50 + 32'(i));
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      wrapData = 32'hA0 + 32'(i);
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("wrap d_out", d_out, wrapData);
    end

    // Simultaneous write and read on empty, mid-level and full
    applyStimulus(1'b1, 1'b1, 32'hC0);
    checkOutput("both empty wr_ack", 32'(wr_ack),     32'd1);
    checkOutput("both empty rd_err", 32'(rd_err),     32'd1);
    checkOutput("both empty count",  32'(data_count), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'hC1);
    applyStimulus(1'b1, 1'b0, 32'hC2);
    applyStimulus(1'b1, 1'b1, 32'hC3);
    checkOutput("both mid wr_ack", 32'(wr_ack),     32'd1);
    checkOutput("both mid rd_ack", 32'(rd_ack),     32'd1);
    checkOutput("both mid count",  32'(data_count), 32'd3);
    checkOutput("both mid d_out",  d_out,           32'hC0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'hD0 + 32'(i));
    checkOutput("pre-full count", 32'(data_count), 32'd8);
    applyStimulus(1'b1, 1'b1, 32'hE0);
    checkOutput("both full rd_ack", 32'(rd_ack),     32'd1);
    checkOutput("both full wr_err", 32'(wr_err),     32'd1);
    checkOutput("both full count",  32'(data_count), 32'd7);
    checkOutput("both full d_out",  d_out,           32'hC1);

    // Asynchronous reset between edges at count 4
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
    checkOutput("pre-reset count", 32'(data_count), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset count",  32'(data_count), 32'd0);
    checkOutput("async reset empty",  32'(empty),      32'd1);
    checkOutput("async reset d_out",  d_out,           32'h0);
    checkOutput("async reset rd_ack", 32'(rd_ack),     32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("post-reset rd_err", 32'(rd_err), 32'd1);

    // Randomized traffic with a write bias that changes every 50 cycles
    for (int blk = 0; blk < 6; blk++) begin
      bias = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
      for (int c = 0; c < 50; c++) begin
        applyStimulus(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias), $urandom);
        if ($urandom_range(0, 9) == 0) applyStimulus(1'b1, 1'b1, $urandom);
      end
    end

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, entry width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2); ADDR_W = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  write request, sampled at rising edge.
REQ-006 SHALL have port rd_en  input  1  read request, sampled at rising edge.
REQ-007 SHALL have port d_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port d_out  output  DATA_WIDTH  registered read data.
REQ-009 SHALL have port full  output  1  high when data_count == DEPTH.
REQ-010 SHALL have port empty  output  1  high when data_count == 0.
REQ-011 SHALL have ports wr_ack, wr_err, rd_ack, rd_err  output  1 each  one-cycle per-request status.
REQ-012 SHALL have port data_count  output  ADDR_W+1  entries currently stored.

Function
REQ-013 SHALL implement an FSM with states INIT, IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR; the state register drives internal control only and is not a port.
REQ-014 SHALL leave INIT for IDLE on the first edge after reset release; requests sampled while in INIT are ignored (no ack, no err, no storage change).
REQ-015 SHALL accept a write when wr_en=1 and full=0 at the edge: mem[tail] <= d_in, tail +1, wr_ack=1 for the next cycle.
REQ-016 SHALL reject a write when wr_en=1 and full=1: storage, tail and count unchanged, wr_err=1 for the next cycle.
REQ-017 SHALL accept a read when rd_en=1 and empty=0: d_out <= mem[head] at that edge (one-cycle latency), head +1, rd_ack=1 for the next cycle.
REQ-018 SHALL reject a read when rd_en=1 and empty=1: d_out holds its value, rd_err=1 for the next cycle.
REQ-019 SHALL hold d_out unchanged on every cycle without an accepted read.
REQ-020 SHALL, with wr_en=rd_en=1 and 0<count<DEPTH, accept both; count unchanged; state WR_RD.
REQ-021 SHALL, with wr_en=rd_en=1 and empty, accept the write, reject the read (no bypass); state RD_ERR; count +1.
REQ-022 SHALL, with wr_en=rd_en=1 and full, accept the read, reject the write; state WR_ERR; count -1.
REQ-023 SHALL select the next state as WR_ERR if a write is rejected, else RD_ERR if a read is rejected, else WR_RD / WRITE / READ by accepted operations, else IDLE.
REQ-024 SHALL wrap head and tail pointers modulo DEPTH (ADDR_W bits, natural overflow).
REQ-025 SHALL update data_count as count + accepted_write - accepted_read, never exceeding DEPTH or going below 0.
REQ-026 SHALL derive full and empty from the registered data_count only (no combinational path from wr_en/rd_en).
REQ-027 SHALL deassert all ack/err outputs in cycles following IDLE/INIT sampling (no request).

Reset
REQ-028 SHALL on reset_n=0, immediately and independent of clk: state INIT, head=tail=0, data_count=0, empty=1, full=0, d_out=0, all ack/err=0.
REQ-029 SHALL discard all stored entries on reset mid-operation; storage array contents need not be cleared.

Structure
REQ-030 SHALL place the FSM state encoding (3-bit constants for the seven states) in shared package fifo_pkg.
REQ-031 SHALL instantiate one sub-module register_bank (parametrised DATA_WIDTH x DEPTH, one-hot write enable, async reset, read-select output) for storage; pointers, count and FSM reside in fifo_param.

Verification
REQ-032 SHALL verify reset: after reset_n release, read with FIFO empty -> rd_err=1, d_out=32'h0, empty=1, data_count=0.
REQ-033 SHALL verify fill: 8 writes 32'h11..32'h88 (DEPTH=8) -> wr_ack each, full=1, data_count=8; 9th write 32'h99 -> wr_err=1, count stays 8.
REQ-034 SHALL verify drain order: 8 reads after fill -> d_out 32'h11..32'h88 in order, rd_ack each, empty=1; 9th read -> rd_err, d_out stays 32'h88.
REQ-035 SHALL verify wrap-around: write 5, read 5, write 6 (32'hA0..A5), read 6 -> data returned A0..A5 in order across pointer wrap.
REQ-036 SHALL verify simultaneous ops: count=3 with wr_en=rd_en=1 -> wr_ack=rd_ack=1, count 3; when empty -> wr_ack=1, rd_err=1, count 1; when full -> rd_ack=1, wr_err=1, count 7.
REQ-037 SHALL verify async reset mid-operation: reset_n low between clk edges at count=4 -> outputs reach reset values before next edge; subsequent read -> rd_err.
